// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory and hands one instruction at a time to decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] inflight_pc_r;
    logic [31:0] redirect_tgt_s;

    assign redirect_tgt_s = {redirect_pc[31:2], 2'b00};

    // Request channel is combinational so a same-cycle redirect can cancel it.
    assign imem_req_valid = (state_r == S_REQ) & ~redirect & ~reset;
    assign imem_req_addr  = pc_r;

    // Fetch FSM with registered decode-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= S_REQ;
            pc_r          <= RESET_PC;
            inflight_pc_r <= 32'h0000_0000;
            ins           <= 32'h0000_0000;
            ins_pc        <= 32'h0000_0000;
            ins_valid     <= 1'b0;
            fetch_count   <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_REQ: begin
                    if (redirect) begin
                        pc_r <= redirect_tgt_s;
                    end else if (imem_req_ready) begin
                        inflight_pc_r <= pc_r;
                        state_r       <= S_WAIT;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid && !redirect) begin
                        ins       <= imem_resp_data;
                        ins_pc    <= inflight_pc_r;
                        ins_valid <= 1'b1;
                        pc_r      <= inflight_pc_r + PC_STEP;
                        state_r   <= S_HOLD;
                    end else if (imem_resp_valid && redirect) begin
                        pc_r    <= redirect_tgt_s;
                        state_r <= S_REQ;
                    end else if (redirect) begin
                        // Response for the squashed fetch is still owed; swallow it in DROP.
                        pc_r    <= redirect_tgt_s;
                        state_r <= S_DROP;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        pc_r <= redirect_tgt_s;
                    end
                    if (imem_resp_valid) begin
                        state_r <= S_REQ;
                    end else begin
                        state_r <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        ins_valid <= 1'b0;
                        pc_r      <= redirect_tgt_s;
                        state_r   <= S_REQ;
                        if (ins_ready) begin
                            fetch_count <= fetch_count + 32'd1;
                        end
                    end else if (ins_ready) begin
                        ins_valid   <= 1'b0;
                        fetch_count <= fetch_count + 32'd1;
                        state_r     <= S_REQ;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: begin
                    state_r   <= S_REQ;
                    ins_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scoreboard bench for instr_fetch: expected instructions are queued
// when a response is driven and checked when decode sees them.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        ins_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req_valid, ins_valid;
    logic [31:0] imem_req_addr, ins, ins_pc, fetch_count;
    logic        imem_req_valid2, ins_valid2;
    logic [31:0] imem_req_addr2, ins2, ins_pc2, fetch_count2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fails   = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .ins(ins), .ins_pc(ins_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .fetch_count(fetch_count)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr2), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .ins(ins2), .ins_pc(ins_pc2),
        .ins_valid(ins_valid2), .ins_ready(ins_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .fetch_count(fetch_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_resp(input logic [31:0] pc, input logic [31:0] data);
        exp_t e;
        e.pc = pc;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        n_asserts++;
        assert (sb.size() != 0) else begin
            n_fails++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, ins_valid}, 32'd1);
            chk({tag, "_ins"}, ins, e.data);
            chk({tag, "_pc"}, ins_pc, e.pc);
        end
    endtask

    initial begin
        reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1;
        chk("rst_ins", ins, 32'h0);
        chk("rst_ins_pc", ins_pc, 32'h0);
        chk("rst_valid", {31'd0, ins_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

        // First fetch from address 0, one-cycle response.
        #11;
        reset = 1'b0; imem_req_ready = 1'b1;
        #1;
        chk("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t1_req_addr", imem_req_addr, 32'h0);
        step();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h8C00_0000;
        push_resp(32'h0, 32'h8C00_0000);
        #1;
        chk("t1_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
        step();
        imem_resp_valid = 1'b0;
        #1;
        pop_check("t1");

        // Decode stalls for 5 cycles in HOLD.
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            chk("t2_stall_ins", ins, 32'h8C00_0000);
            chk("t2_stall_pc", ins_pc, 32'h0);
            chk("t2_stall_valid", {31'd0, ins_valid}, 32'd1);
            chk("t2_stall_noreq", {31'd0, imem_req_valid}, 32'd0);
        end
        ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        #1;
        chk("t2_count", fetch_count, 32'd1);
        chk("t2_valid_drop", {31'd0, ins_valid}, 32'd0);
        chk("t2_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t2_req_addr", imem_req_addr, 32'h4);

        // Redirect in WAIT, response three cycles later is discarded.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        chk("t3_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("t3_drop_valid", {31'd0, ins_valid}, 32'd0);
        step();
        #1;
        chk("t3_drop_noreq", {31'd0, imem_req_valid}, 32'd0);
        step();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        #1;
        chk("t3_valid", {31'd0, ins_valid}, 32'd0);
        chk("t3_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t3_req_addr", imem_req_addr, 32'h0000_0100);
        chk("t3_count", fetch_count, 32'd1);

        // Redirect and response together in WAIT.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0001;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        imem_resp_valid = 1'b0; redirect = 1'b0;
        #1;
        chk("t4_valid", {31'd0, ins_valid}, 32'd0);
        chk("t4_req_addr", imem_req_addr, 32'h0000_0200);
        chk("t4_req_valid", {31'd0, imem_req_valid}, 32'd1);
        // Redirect while requesting cancels the request and moves the PC.
        imem_req_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0206;
        #1;
        chk("t4_req_redirect_noreq", {31'd0, imem_req_valid}, 32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("t4_req_redirect_addr", imem_req_addr, 32'h0000_0204);
        chk("t4_req_redirect_valid", {31'd0, imem_req_valid}, 32'd1);

        // Redirect with ins_ready in HOLD.
        step();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
        push_resp(32'h0000_0204, 32'h1234_5678);
        step();
        imem_resp_valid = 1'b0;
        #1;
        pop_check("t5");
        redirect = 1'b1; redirect_pc = 32'h0000_0300; ins_ready = 1'b1;
        step();
        redirect = 1'b0; ins_ready = 1'b0;
        #1;
        chk("t5_count", fetch_count, 32'd2);
        chk("t5_valid", {31'd0, ins_valid}, 32'd0);
        chk("t5_req_addr", imem_req_addr, 32'h0000_0300);
        // Stray response in REQ is ignored.
        imem_resp_valid = 1'b1; imem_resp_data = 32'hFFFF_0000;
        step();
        imem_resp_valid = 1'b0;
        #1;
        chk("t5_stray_valid", {31'd0, ins_valid}, 32'd0);
        chk("t5_stray_addr", imem_req_addr, 32'h0000_0300);
        chk("t5_stray_req", {31'd0, imem_req_valid}, 32'd1);

        // PC wrap on the high RESET_PC instance, then async reset mid-WAIT.
        reset = 1'b1;
        #1;
        chk("t6_rst_noreq", {31'd0, imem_req_valid}, 32'd0);
        step();
        reset = 1'b0; imem_req_ready = 1'b1;
        #1;
        chk("t6_req_addr0", imem_req_addr2, 32'hFFFF_FFFC);
        chk("t6_req_valid0", {31'd0, imem_req_valid2}, 32'd1);
        step();
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hA5A5_0001;
        step();
        imem_resp_valid = 1'b0; ins_ready = 1'b1;
        #1;
        chk("t6_ins", ins2, 32'hA5A5_0001);
        chk("t6_ins_pc", ins_pc2, 32'hFFFF_FFFC);
        chk("t6_valid", {31'd0, ins_valid2}, 32'd1);
        step();
        ins_ready = 1'b0; imem_req_ready = 1'b1;
        #1;
        chk("t6_wrap_addr", imem_req_addr2, 32'h0);
        chk("t6_wrap_req", {31'd0, imem_req_valid2}, 32'd1);
        chk("t6_count", fetch_count2, 32'd1);
        step();
        imem_req_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_arst_ins", ins2, 32'h0);
        chk("t6_arst_pc", ins_pc2, 32'h0);
        chk("t6_arst_valid", {31'd0, ins_valid2}, 32'd0);
        chk("t6_arst_count", fetch_count2, 32'h0);
        chk("t6_arst_req", {31'd0, imem_req_valid2}, 32'd0);
        chk("t6_arst_addr", imem_req_addr2, 32'hFFFF_FFFC);
        chk("t6_arst_ins_a", ins, 32'h0);
        chk("t6_arst_count_a", fetch_count, 32'h0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
